mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Responder end of the CPU byte-wide memory bus: serves every mem_addr/mem_wr/mem_dout access issued by the core.
//  Holds a byte RAM plus the memory-mapped I/O page at 0x30000: UART TX FIFO, RX byte input, cycle counter and stop flag.
//  Drives rdy_out to freeze the core while the TX FIFO cannot take more bytes.
// PARAMETERS
//  RAM_AW       17  RAM byte-address width; RAM covers 0x0 .. 2**RAM_AW-1
//  TXF_AW       3   log2 of TX FIFO depth (depth 8)
// PORTS
//  clk_in       in   1   clock; all state changes on posedge
//  rst_in       in   1   reset, asynchronous, active-high
//  mem_addr     in   32  byte address from core
//  mem_dout     in   8   write byte from core
//  mem_wr       in   1   1 = write this cycle, 0 = read
//  mem_din      out  8   read byte returned to core, registered
//  rdy_out      out  1   1 = core may run; 0 = core must pause
//  rx_data      in   8   input byte offered by host
//  rx_valid     in   1   rx_data holds an unread byte
//  rx_ready     out  1   one-cycle pop pulse to host RX source
//  tx_data      out  8   head byte of TX FIFO
//  tx_valid     out  1   TX FIFO non-empty
//  tx_ready     in   1   host accepts tx_data this cycle
//  program_stop out  1   sticky; set by write to 0x30004
//  tx_overflow  out  1   sticky; a TX push was dropped on full FIFO
// BEHAVIOUR
//  Reset: mem_din=0, rx_ready=0, FIFO empty (tx_valid=0, tx_data=0), counter=0, snapshot=0, program_stop=0,
//   tx_overflow=0, rdy_out=1. RAM contents not cleared. Reset mid-transfer discards pending read and FIFO contents.
//  Decode: io = (mem_addr[17:16]==2'b11); else RAM at mem_addr[RAM_AW-1:0]; upper bits ignored.
//  Read latency 1: address sampled at posedge N, mem_din valid after posedge N+1 edge is not needed (valid whole cycle N+1).
//   mem_din holds its value until the next read is sampled; writes do not change mem_din.
//  RAM write: mem_wr=1, !io -> byte stored at posedge; same-cycle read of same address impossible (single port).
//  IO map (mem_addr[2:0] within page, other IO addresses read 0x00 and ignore writes):
//   0x30000 R: rx_valid ? rx_data : 0x00; rx_ready=1 for exactly that cycle only when rx_valid=1.
//   0x30000 W: mem_dout!=0 -> push to TX FIFO; mem_dout==0 ignored.
//   0x30004..07 R: byte mem_addr[1:0] of 32-bit snapshot, little-endian; reading 0x30004 loads
//    snapshot<=counter in same edge and returns counter[7:0]; 0x30005..07 return snapshot bytes (coherent dword).
//   0x30004 W: program_stop<=1 and push 0x00 to TX FIFO (only place a zero is pushed).
//  Counter: 32-bit, +1 every clk_in after reset, wraps 0xFFFFFFFF->0; not paused by rdy_out.
//  TX FIFO: circular, wr/rd pointers TXF_AW bits + count TXF_AW+1 bits; pointers wrap at depth.
//   pop when tx_valid && tx_ready; push per IO map.
//   push+pop same cycle: both happen, count unchanged (also legal when full or empty-with-push? empty: pop invalid, push only).
//   push while full and no pop: byte dropped, tx_overflow<=1.
//  rdy_out = (count < depth-1), combinational from count: drops with one slot spare so the
//   write in flight when rdy_out falls is still accepted.
//  State: TX FIFO state machine implicit in count: EMPTY (0) -> PARTIAL -> ALMOST (depth-1, rdy_out=0) -> FULL.
// TESTING
//  RAM: write 0xA5 @0x00010, then read 0x00010 -> mem_din=0xA5 one cycle after the read address; read 0x1FFFF after write 0x3C -> 0x3C.
//  TX: tx_ready=0, write 0x41 then 0x00 to 0x30000 -> tx_valid=1, tx_data=0x41, count=1; tx_ready=1 -> tx_valid=0 next cycle.
//  Full: tx_ready=0, 7 writes -> rdy_out=0 after 7th; 8th accepted, 9th dropped, tx_overflow=1; one pop + push same cycle keeps count=8.
//  RX: rx_valid=1, rx_data=0x5A, read 0x30000 -> mem_din=0x5A, rx_ready one-cycle pulse; rx_valid=0 -> 0x00, no pulse.
//  Counter: 100 cycles after reset read 0x30004..07 -> bytes of snapshot (100, 0,0,0) even though counter advanced; preload 0xFFFFFFFF wraps to 0.
//  Stop/reset: write 0x30004 -> program_stop=1, 0x00 in FIFO; assert rst_in mid-burst -> all outputs to reset values asynchronously.

Source files
------------

// File: rtl/mem_io_responder.sv
// Responder for the core's byte-wide memory bus: byte RAM plus an I/O page at 0x30000
// holding the UART TX FIFO, RX byte input, free-running cycle counter and stop flag.
module mem_io_responder #(
  parameter int RAM_AW = 17,
  parameter int TXF_AW = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_addr,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        rdy_out,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int DEPTH = 1 << TXF_AW;
  localparam logic [TXF_AW:0]   FULL_LVL   = (TXF_AW+1)'(DEPTH);
  localparam logic [TXF_AW:0]   ALMOST_LVL = (TXF_AW+1)'(DEPTH - 1);
  localparam logic [TXF_AW:0]   CNT_ONE    = (TXF_AW+1)'(1);
  localparam logic [TXF_AW-1:0] PTR_ONE    = TXF_AW'(1);

  typedef enum logic [1:0] {LVL_EMPTY, LVL_PARTIAL, LVL_ALMOST, LVL_FULL} tx_level_e;

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        ram_q;
  logic [7:0]        io_q;
  logic              sel_io_q;
  logic [31:0]       counter;
  logic [31:0]       snapshot;
  logic [7:0]        fifo_mem [DEPTH];
  logic [TXF_AW-1:0] wr_ptr;
  logic [TXF_AW-1:0] rd_ptr;
  logic [TXF_AW:0]   tx_count;
  tx_level_e         tx_level;

  logic              io_sel;
  logic              io_rd;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        io_rdata;
  logic              push_req;
  logic [7:0]        push_byte;
  logic              do_push;
  logic              do_pop;
  logic              unused_addr_bits;

  assign io_sel           = (mem_addr[17:16] == 2'b11);
  assign io_rd            = io_sel && !mem_wr;
  assign ram_addr         = mem_addr[RAM_AW-1:0];
  assign unused_addr_bits = ^mem_addr[31:18];

  always_comb begin
    io_rdata = 8'h00;
    case (mem_addr[2:0])
      3'd0:    io_rdata = rx_valid ? rx_data : 8'h00;
      3'd4:    io_rdata = counter[7:0];
      3'd5:    io_rdata = snapshot[15:8];
      3'd6:    io_rdata = snapshot[23:16];
      3'd7:    io_rdata = snapshot[31:24];
      default: io_rdata = 8'h00;
    endcase
  end

  // Zero bytes written to the data port are swallowed; the stop register is the only source of a zero byte.
  always_comb begin
    push_req  = 1'b0;
    push_byte = mem_dout;
    if (io_sel && mem_wr) begin
      if (mem_addr[2:0] == 3'd0) begin
        push_req = (mem_dout != 8'h00);
      end else if (mem_addr[2:0] == 3'd4) begin
        push_req  = 1'b1;
        push_byte = 8'h00;
      end
    end
  end

  assign do_pop  = (tx_count != '0) && tx_ready;
  assign do_push = push_req && ((tx_count != FULL_LVL) || do_pop);

  // Single-port RAM; the read register only moves on RAM reads so mem_din holds across writes.
  always_ff @(posedge clk_in) begin
    if (!io_sel) begin
      if (mem_wr) ram[ram_addr] <= mem_dout;
      else        ram_q         <= ram[ram_addr];
    end
  end

  // Reset selects the zeroed I/O register, which drops any read in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sel_io_q <= 1'b1;
      io_q     <= 8'h00;
      rx_ready <= 1'b0;
      snapshot <= 32'h0;
      counter  <= 32'h0;
    end else begin
      counter  <= counter + 32'd1;
      rx_ready <= io_rd && (mem_addr[2:0] == 3'd0) && rx_valid;
      if (!mem_wr) begin
        sel_io_q <= io_sel;
        if (io_sel) io_q <= io_rdata;
      end
      if (io_rd && (mem_addr[2:0] == 3'd4)) snapshot <= counter;
    end
  end

  assign mem_din = sel_io_q ? io_q : ram_q;

  always_ff @(posedge clk_in) begin
    if (do_push) fifo_mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      tx_count     <= '0;
      tx_overflow  <= 1'b0;
      program_stop <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
      if (push_req && !do_push) tx_overflow <= 1'b1;
      if (io_sel && mem_wr && (mem_addr[2:0] == 3'd4)) program_stop <= 1'b1;
    end
  end

  always_comb begin
    tx_level = LVL_PARTIAL;
    if (tx_count == '0)             tx_level = LVL_EMPTY;
    else if (tx_count == FULL_LVL)  tx_level = LVL_FULL;
    else if (tx_count == ALMOST_LVL) tx_level = LVL_ALMOST;
  end

  // Stall one slot early so the store already issued when rdy_out falls still fits.
  assign rdy_out  = (tx_level == LVL_EMPTY) || (tx_level == LVL_PARTIAL);
  assign tx_valid = (tx_level != LVL_EMPTY);
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder: RAM, TX FIFO fill/overflow/drain,
// RX read handshake, counter snapshot, stop flag and asynchronous reset.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_addr = 32'h0003_0001;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_din;
  logic        rdy_out;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        program_stop;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  mem_io_responder #(.RAM_AW(17), .TXF_AW(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
    .rdy_out(rdy_out),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one bus cycle at a falling edge and returns at the next falling edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr, input logic [7:0] dout);
    mem_addr = addr;
    mem_wr   = wr;
    mem_dout = dout;
    @(negedge clk_in);
  endtask

  task automatic idleBus();
    mem_addr = 32'h0003_0001;
    mem_wr   = 1'b0;
    mem_dout = 8'h00;
  endtask

  logic [7:0] drain_exp [8] = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'hAB};

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    checkOutput("rst_mem_din", 32'(mem_din), 32'h00);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'h0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("rst_program_stop", 32'(program_stop), 32'h0);
    checkOutput("rst_tx_overflow", 32'(tx_overflow), 32'h0);
    checkOutput("rst_rdy_out", 32'(rdy_out), 32'h1);
    rst_in = 1'b0;

    // Counter: read sampled on the 101st edge after reset sees counter == 100.
    idleBus();
    repeat (100) @(negedge clk_in);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("cnt_byte0", 32'(mem_din), 32'd100);
    applyStimulus(32'h0003_0005, 1'b0, 8'h00);
    checkOutput("cnt_byte1", 32'(mem_din), 32'h00);
    applyStimulus(32'h0003_0006, 1'b0, 8'h00);
    checkOutput("cnt_byte2", 32'(mem_din), 32'h00);
    applyStimulus(32'h0003_0007, 1'b0, 8'h00);
    checkOutput("cnt_byte3", 32'(mem_din), 32'h00);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00);
    checkOutput("cnt_reread", 32'(mem_din), 32'd104);

    // RAM
    applyStimulus(32'h0000_0010, 1'b1, 8'hA5);
    applyStimulus(32'h0001_FFFF, 1'b1, 8'h3C);
    applyStimulus(32'h0000_0010, 1'b0, 8'h00);
    checkOutput("ram_rd_10", 32'(mem_din), 32'hA5);
    applyStimulus(32'h0000_0050, 1'b1, 8'h77);
    checkOutput("ram_wr_holds_din", 32'(mem_din), 32'hA5);
    applyStimulus(32'h0001_FFFF, 1'b0, 8'h00);
    checkOutput("ram_rd_top", 32'(mem_din), 32'h3C);
    applyStimulus(32'hFFF4_0010, 1'b0, 8'h00);
    checkOutput("ram_upper_ignored", 32'(mem_din), 32'hA5);
    applyStimulus(32'h0003_0002, 1'b0, 8'h00);
    checkOutput("io_unmapped_rd", 32'(mem_din), 32'h00);

    // TX single byte; zero to the data port is ignored
    applyStimulus(32'h0003_0000, 1'b1, 8'h41);
    applyStimulus(32'h0003_0000, 1'b1, 8'h00);
    idleBus();
    checkOutput("tx_valid_one", 32'(tx_valid), 32'h1);
    checkOutput("tx_data_one", 32'(tx_data), 32'h41);
    tx_ready = 1'b1;
    @(negedge clk_in);
    checkOutput("tx_empty_after_pop", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // Fill to full, overflow, then simultaneous push and pop
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(32'h0003_0000, 1'b1, (i == 9) ? 8'h99 : 8'(8'h10 + i));
      if (i == 6) checkOutput("rdy_at_6", 32'(rdy_out), 32'h1);
      if (i == 7) checkOutput("rdy_at_7", 32'(rdy_out), 32'h0);
      if (i == 8) checkOutput("ovf_at_8", 32'(tx_overflow), 32'h0);
      if (i == 9) checkOutput("ovf_at_9", 32'(tx_overflow), 32'h1);
    end
    tx_ready = 1'b1;
    applyStimulus(32'h0003_0000, 1'b1, 8'hAB);
    idleBus();
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("drain_valid_%0d", k), 32'(tx_valid), 32'h1);
      checkOutput($sformatf("drain_data_%0d", k), 32'(tx_data), 32'(drain_exp[k]));
      checkOutput($sformatf("drain_rdy_%0d", k), 32'(rdy_out), (k >= 2) ? 32'h1 : 32'h0);
      @(negedge clk_in);
    end
    checkOutput("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    // RX
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    idleBus();
    checkOutput("rx_data_read", 32'(mem_din), 32'h5A);
    checkOutput("rx_ready_pulse", 32'(rx_ready), 32'h1);
    rx_valid = 1'b0;
    @(negedge clk_in);
    checkOutput("rx_ready_one_cycle", 32'(rx_ready), 32'h0);
    applyStimulus(32'h0003_0000, 1'b0, 8'h00);
    checkOutput("rx_empty_read", 32'(mem_din), 32'h00);
    checkOutput("rx_no_pulse", 32'(rx_ready), 32'h0);

    // Stop register pushes a single zero byte
    applyStimulus(32'h0003_0004, 1'b1, 8'h55);
    idleBus();
    checkOutput("stop_flag", 32'(program_stop), 32'h1);
    checkOutput("stop_tx_valid", 32'(tx_valid), 32'h1);
    checkOutput("stop_tx_data", 32'(tx_data), 32'h00);

    // Asynchronous reset in the middle of a burst
    applyStimulus(32'h0000_0010, 1'b0, 8'h00);
    applyStimulus(32'h0003_0000, 1'b1, 8'h61);
    applyStimulus(32'h0003_0000, 1'b1, 8'h62);
    checkOutput("pre_rst_din", 32'(mem_din), 32'hA5);
    #2 rst_in = 1'b1;
    #1;
    checkOutput("arst_mem_din", 32'(mem_din), 32'h00);
    checkOutput("arst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("arst_tx_data", 32'(tx_data), 32'h00);
    checkOutput("arst_program_stop", 32'(program_stop), 32'h0);
    checkOutput("arst_tx_overflow", 32'(tx_overflow), 32'h0);
    checkOutput("arst_rdy_out", 32'(rdy_out), 32'h1);
    idleBus();
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    checkOutput("post_rst_tx_valid", 32'(tx_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
